// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the two-port memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arbState_e;

  typedef enum logic {
    GNT_IC = 1'b0,
    GNT_DC = 1'b1
  } grant_e;

  localparam int TIMEOUT_DEFAULT = 16;
  localparam int CNT_W           = 5;

endpackage

// File: rtl/arb_rr2.sv
// rtl/arb_rr2.sv - two-requester round-robin grant selection
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic icReq,
  input  logic dcReq,
  input  logic lastGnt,
  output logic gntValid,
  output logic gnt
);

  always_comb begin
    gntValid = icReq | dcReq;
    gnt      = GNT_IC;
    if (icReq && dcReq) begin
      // On a tie the side that did not win last time gets the grant.
      gnt = (lastGnt == GNT_IC) ? GNT_DC : GNT_IC;
    end else if (dcReq) begin
      gnt = GNT_DC;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates I-cache and D-cache requests onto one memory port
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ic_req,
  input  logic [15:0] ic_addr,
  output logic        ic_done,
  output logic        ic_err,
  output logic [15:0] ic_rdata,
  input  logic        dc_req,
  input  logic        dc_wr,
  input  logic [15:0] dc_addr,
  input  logic [15:0] dc_wdata,
  output logic        dc_done,
  output logic        dc_err,
  output logic [15:0] dc_rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic        mem_done,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  arbState_e        state;
  logic             lastGnt;
  logic             winner;
  logic             opWr;
  logic [15:0]      addrLat;
  logic [15:0]      wdataLat;
  logic [CNT_W-1:0] waitCnt;
  logic [CNT_W-1:0] waitCntNext;
  logic             timeoutHit;
  logic             rrValid;
  logic             rrGnt;

  arb_rr2 uRr (
    .icReq   (ic_req),
    .dcReq   (dc_req),
    .lastGnt (lastGnt),
    .gntValid(rrValid),
    .gnt     (rrGnt)
  );

  assign waitCntNext = (waitCnt == {CNT_W{1'b1}}) ? waitCnt : waitCnt + 1'b1;
  assign timeoutHit  = (int'(waitCntNext) >= TIMEOUT);

  assign mem_addr  = addrLat;
  assign mem_wdata = wdataLat;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lastGnt  <= GNT_IC;
      winner   <= GNT_IC;
      opWr     <= 1'b0;
      addrLat  <= '0;
      wdataLat <= '0;
      waitCnt  <= '0;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      ic_done  <= 1'b0;
      ic_err   <= 1'b0;
      ic_rdata <= '0;
      dc_done  <= 1'b0;
      dc_err   <= 1'b0;
      dc_rdata <= '0;
    end else begin
      // Strobes and response pulses default low so each lasts exactly one cycle.
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      ic_done  <= 1'b0;
      ic_err   <= 1'b0;
      ic_rdata <= '0;
      dc_done  <= 1'b0;
      dc_err   <= 1'b0;
      dc_rdata <= '0;
      case (state)
        IDLE: begin
          if (rrValid) begin
            winner  <= rrGnt;
            lastGnt <= rrGnt;
            state   <= ISSUE;
            if (rrGnt == GNT_DC) begin
              addrLat  <= dc_addr;
              wdataLat <= dc_wdata;
              opWr     <= dc_wr;
              mem_wr   <= dc_wr;
              mem_rd   <= ~dc_wr;
            end else begin
              addrLat  <= ic_addr;
              wdataLat <= '0;
              opWr     <= 1'b0;
              mem_rd   <= 1'b1;
            end
          end
        end
        ISSUE: begin
          waitCnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          waitCnt <= waitCntNext;
          // A completion on the final allowed cycle still wins over the timeout.
          if (mem_done) begin
            state <= RESP;
            if (winner == GNT_DC) begin
              dc_done  <= 1'b1;
              dc_rdata <= opWr ? 16'h0000 : mem_rdata;
            end else begin
              ic_done  <= 1'b1;
              ic_rdata <= mem_rdata;
            end
          end else if (timeoutHit) begin
            state <= RESP;
            if (winner == GNT_DC) begin
              dc_done <= 1'b1;
              dc_err  <= 1'b1;
            end else begin
              ic_done <= 1'b1;
              ic_err  <= 1'b1;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a memory responder and scoreboards
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        ic_req;
  logic [15:0] ic_addr;
  logic        ic_done;
  logic        ic_err;
  logic [15:0] ic_rdata;
  logic        dc_req;
  logic        dc_wr;
  logic [15:0] dc_addr;
  logic [15:0] dc_wdata;
  logic        dc_done;
  logic        dc_err;
  logic [15:0] dc_rdata;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_done;
  logic [15:0] mem_rdata;
  logic        busy;

  logic        memDoneResp;
  logic [15:0] memRdataResp;
  logic        memDoneForce;
  logic        memSilent;
  int          memLat;
  logic [15:0] memData;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        isDc;
    logic [15:0] rdata;
    logic        err;
  } res_t;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } strb_t;

  typedef struct {
    logic        isDc;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          lat;
    logic        silent;
    logic [15:0] data;
    logic [15:0] expRdata;
    logic        expErr;
    int          expLat;
  } vec_t;

  res_t  expRes[$];
  strb_t expStrb[$];

  assign mem_done  = memDoneResp | memDoneForce;
  assign mem_rdata = memDoneForce ? 16'hDEAD : memRdataResp;

  mem_arbiter #(.TIMEOUT(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .ic_req   (ic_req),
    .ic_addr  (ic_addr),
    .ic_done  (ic_done),
    .ic_err   (ic_err),
    .ic_rdata (ic_rdata),
    .dc_req   (dc_req),
    .dc_wr    (dc_wr),
    .dc_addr  (dc_addr),
    .dc_wdata (dc_wdata),
    .dc_done  (dc_done),
    .dc_err   (dc_err),
    .dc_rdata (dc_rdata),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_done (mem_done),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: answers each strobe memLat cycles later unless told to stay silent.
  initial begin
    memDoneResp  = 1'b0;
    memRdataResp = 16'h0000;
    forever begin
      @(negedge clk);
      if ((mem_rd || mem_wr) && !memSilent) begin
        repeat (memLat) @(negedge clk);
        memDoneResp  = 1'b1;
        memRdataResp = memData;
        @(negedge clk);
        memDoneResp  = 1'b0;
        memRdataResp = 16'h0000;
      end
    end
  end

  // Output monitor: pops scoreboards on each response and strobe.
  always @(negedge clk) begin
    res_t  r;
    strb_t s;
    if (ic_done || dc_done) begin
      if (expRes.size() == 0) begin
        chk("doneUnexpected", 32'(ic_done | dc_done), 32'd0);
      end else begin
        r = expRes.pop_front();
        chk("doneWho", 32'({ic_done, dc_done}), r.isDc ? 32'd1 : 32'd2);
        chk("doneRdata", 32'(r.isDc ? dc_rdata : ic_rdata), 32'(r.rdata));
        chk("doneErr", 32'(r.isDc ? dc_err : ic_err), 32'(r.err));
      end
    end
    chk("icQuiet", ic_done ? 32'd0 : 32'({ic_err, ic_rdata}), 32'd0);
    chk("dcQuiet", dc_done ? 32'd0 : 32'({dc_err, dc_rdata}), 32'd0);
    if (mem_rd || mem_wr) begin
      if (expStrb.size() == 0) begin
        chk("strobeUnexpected", 32'({mem_rd, mem_wr}), 32'd0);
      end else begin
        s = expStrb.pop_front();
        chk("strobeOp", 32'({mem_rd, mem_wr}), s.wr ? 32'd1 : 32'd2);
        chk("strobeAddr", 32'(mem_addr), 32'(s.addr));
        chk("strobeWdata", 32'(mem_wdata), 32'(s.wdata));
      end
    end
  end

  task automatic waitDone(output int lat);
    int n;
    n = 0;
    while (!(ic_done || dc_done) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("doneTimeout", 32'd1, 32'd0);
    lat = n;
  endtask

  task automatic runSingle(input vec_t v);
    int lat;
    ic_req    = ~v.isDc;
    ic_addr   = v.addr;
    dc_req    = v.isDc;
    dc_wr     = v.wr;
    dc_addr   = v.addr;
    dc_wdata  = v.isDc ? v.wdata : 16'h0000;
    memSilent = v.silent;
    memLat    = v.lat;
    memData   = v.data;
    expStrb.push_back('{v.isDc & v.wr, v.addr, v.isDc ? v.wdata : 16'h0000});
    expRes.push_back('{v.isDc, v.expRdata, v.expErr});
    waitDone(lat);
    chk("latency", 32'(lat), 32'(v.expLat));
    ic_req = 1'b0;
    dc_req = 1'b0;
    @(negedge clk);
    chk("busyAfterResp", 32'(busy), 32'd0);
  endtask

  // Both requesters stay high throughout, so grants must alternate starting with D-cache.
  task automatic runTie(input int n);
    int lat;
    for (int i = 0; i < n; i++) begin
      expStrb.push_back('{1'b0, (i % 2 == 0) ? 16'h0300 : 16'h0200, 16'h0000});
      expRes.push_back('{(i % 2 == 0), 16'h0A0A, 1'b0});
    end
    memSilent = 1'b0;
    memLat    = 1;
    memData   = 16'h0A0A;
    ic_addr   = 16'h0200;
    dc_addr   = 16'h0300;
    dc_wr     = 1'b0;
    dc_wdata  = 16'h0000;
    ic_req    = 1'b1;
    dc_req    = 1'b1;
    for (int i = 0; i < n; i++) begin
      waitDone(lat);
      chk("tieLatency", 32'(lat), 32'd3);
      if (i == n - 1) begin
        ic_req = 1'b0;
        dc_req = 1'b0;
      end
      @(negedge clk);
    end
    chk("busyAfterTie", 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t vecs[7];
    vecs[0] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 2,  1'b0, 16'hBEEF, 16'hBEEF, 1'b0, 4};
    vecs[1] = '{1'b1, 1'b1, 16'h0010, 16'h1234, 1,  1'b0, 16'h5555, 16'h0000, 1'b0, 3};
    vecs[2] = '{1'b0, 1'b0, 16'h0123, 16'h0000, 1,  1'b0, 16'hCAFE, 16'hCAFE, 1'b0, 3};
    vecs[3] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 5,  1'b0, 16'h0001, 16'h0001, 1'b0, 7};
    vecs[4] = '{1'b1, 1'b0, 16'h8000, 16'h0000, 16, 1'b0, 16'h7777, 16'h7777, 1'b0, 18};
    vecs[5] = '{1'b1, 1'b0, 16'h0555, 16'h0000, 1,  1'b1, 16'h9999, 16'h0000, 1'b1, 18};
    vecs[6] = '{1'b0, 1'b0, 16'h0666, 16'h0000, 1,  1'b1, 16'h9999, 16'h0000, 1'b1, 18};

    rst          = 1'b1;
    ic_req       = 1'b0;
    ic_addr      = 16'h0000;
    dc_req       = 1'b0;
    dc_wr        = 1'b0;
    dc_addr      = 16'h0000;
    dc_wdata     = 16'h0000;
    memDoneForce = 1'b0;
    memSilent    = 1'b1;
    memLat       = 1;
    memData      = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rstBusy", 32'(busy), 32'd0);
    chk("rstStrobes", 32'({mem_rd, mem_wr}), 32'd0);
    chk("rstIcOut", 32'({ic_done, ic_err, ic_rdata}), 32'd0);
    chk("rstDcOut", 32'({dc_done, dc_err, dc_rdata}), 32'd0);
    chk("rstMemBus", 32'({mem_addr, mem_wdata}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Stray completion while idle must be ignored.
    memDoneForce = 1'b1;
    @(negedge clk);
    memDoneForce = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("idleMemDoneBusy", 32'(busy), 32'd0);
    end

    runTie(4);

    for (int i = 0; i < 7; i++) runSingle(vecs[i]);

    // Late completion after a timeout must not produce anything.
    memDoneForce = 1'b1;
    @(negedge clk);
    memDoneForce = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("strayAfterTimeoutBusy", 32'(busy), 32'd0);
    end

    // Reset in the middle of a D-cache wait aborts silently.
    memSilent = 1'b1;
    dc_addr   = 16'h0440;
    dc_wr     = 1'b0;
    dc_wdata  = 16'h0000;
    dc_req    = 1'b1;
    expStrb.push_back('{1'b0, 16'h0440, 16'h0000});
    repeat (4) @(negedge clk);
    chk("busyInWait", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("busyAfterRst", 32'(busy), 32'd0);
    rst    = 1'b0;
    dc_req = 1'b0;
    repeat (3) @(negedge clk);
    memDoneForce = 1'b1;
    @(negedge clk);
    memDoneForce = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("lateMemDoneBusy", 32'(busy), 32'd0);
    end

    runTie(2);

    chk("resQueueEmpty", 32'(expRes.size()), 32'd0);
    chk("strbQueueEmpty", 32'(expStrb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
